// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Counter must hold 0..WIDTH-1 for every legal WIDTH.
   function automatic int unsigned cnt_w(int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/fulladdar.sv
// One-bit combinational full-adder cell.
module fulladdar (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic sum_o,
   output logic carry_o
);

   assign sum_o   = a_i ^ b_i ^ c_i;
   assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a single full-adder cell, LSB first.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   serial_adder_if.slave bus
);
   import serial_adder_pkg::*;

   localparam int unsigned     CntW    = cnt_w(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] sum_shift;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_sum, fa_carry;
   logic             last_bit;

   fulladdar u_fa (
      .a_i     (a_sr_q[0]),
      .b_i     (b_sr_q[0]),
      .c_i     (carry_q),
      .sum_o   (fa_sum),
      .carry_o (fa_carry)
   );

   assign last_bit  = (cnt_q == LastCnt);
   // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   assign sum_shift = (sum_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StShift;
         StShift: if (last_bit)  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state_q)
         StShift: bus.busy = 1'b1;
         StDone:  bus.done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      if (state_q == StIdle && bus.start) begin
         a_sr_d  = bus.a;
         b_sr_d  = bus.b;
         carry_d = bus.cin;
         cnt_d   = '0;
      end else if (state_q == StShift) begin
         a_sr_d   = a_sr_q >> 1;
         b_sr_d   = b_sr_q >> 1;
         sum_sr_d = sum_shift;
         carry_d  = fa_carry;
         cnt_d    = cnt_q + CntW'(1);
         if (last_bit) begin
            sum_d  = sum_shift;
            cout_d = fa_carry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for the 8-bit serial adder.
module tb_serial_adder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   serial_adder_if #(.WIDTH(8)) bus ();

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns after the cycle following done.
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] prev_sum, input logic prev_cout,
                         output logic [7:0] s, output logic co);
      int busy_n;
      int lat;
      logic stable;
      bus.a = a;
      bus.b = b;
      bus.cin = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      busy_n = 0;
      lat = 1;
      stable = 1'b1;
      while (!bus.done && lat < 30) begin
         if (bus.busy) busy_n++;
         if (bus.sum !== prev_sum || bus.cout !== prev_cout) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, lat, 9);
      chk({name, " busy_cycles"}, busy_n, 8);
      chk({name, " hold"}, {31'd0, stable}, 1);
      s = bus.sum;
      co = bus.cout;
      @(negedge clk);
      chk({name, " done_pulse"}, {30'd0, bus.done, bus.busy}, 0);
   endtask

   initial begin
      logic [7:0] s;
      logic       co;
      logic [7:0] prev_s;
      logic       prev_co;
      int         lat;
      logic       stable;
      int         done_cnt;
      int         done_at[3];
      logic       busy_at[40];

      checks = 0;
      errors = 0;
      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
      vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      // Reset held with start asserted.
      rst_n = 1'b0;
      bus.start = 1'b1;
      bus.a = 8'h01;
      bus.b = 8'h02;
      bus.cin = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_outputs", {20'd0, bus.busy, bus.done, bus.cout, bus.sum}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_start_accepted", {31'd0, bus.busy}, 1);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("post_reset_sum", {23'd0, bus.cout, bus.sum}, 9'h003);
      @(negedge clk);
      prev_s = 8'h03;
      prev_co = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, prev_s, prev_co,
                s, co);
         chk($sformatf("vec%0d result", i), {23'd0, co, s}, {23'd0, vecs[i].exp_cout,
             vecs[i].exp_sum});
         prev_s = vecs[i].exp_sum;
         prev_co = vecs[i].exp_cout;
      end

      // start re-asserted with new operands mid-operation must be ignored.
      bus.a = 8'h10;
      bus.b = 8'h20;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.a = 8'hAA;
      bus.b = 8'h55;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 4;
      stable = 1'b1;
      while (!bus.done && lat < 30) begin
         if (bus.sum !== prev_s || bus.cout !== prev_co) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk("ignore latency", lat, 9);
      chk("ignore hold", {31'd0, stable}, 1);
      chk("ignore result", {23'd0, bus.cout, bus.sum}, 9'h030);
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_cnt++;
      end
      chk("ignore no_second_op", done_cnt, 0);

      // Reset four cycles into SHIFT discards the partial result.
      bus.a = 8'h5A;
      bus.b = 8'h3C;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midreset outputs", {20'd0, bus.busy, bus.done, bus.cout, bus.sum}, 0);
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      chk("midreset no_done", done_cnt, 0);
      run_op("after_reset", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, s, co);
      chk("after_reset result", {23'd0, co, s}, 9'h002);

      // start tied high: one operation per WIDTH+2 cycles.
      bus.a = 8'h03;
      bus.b = 8'h04;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      done_cnt = 0;
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         busy_at[i] = bus.busy;
         if (bus.done) begin
            if (done_cnt < 3) done_at[done_cnt] = i;
            done_cnt++;
         end
      end
      bus.start = 1'b0;
      chk("b2b done_count", done_cnt, 3);
      chk("b2b first_done", done_at[0], 9);
      chk("b2b period1", done_at[1] - done_at[0], 10);
      chk("b2b period2", done_at[2] - done_at[1], 10);
      chk("b2b idle_after_done", {31'd0, busy_at[10]}, 0);
      chk("b2b reaccept", {31'd0, busy_at[11]}, 1);
      chk("b2b result", {23'd0, bus.cout, bus.sum}, 9'h007);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder: loads two operands and a carry-in on a start strobe, then feeds one bit pair per clock, LSB first, into a 1-bit full-adder cell.
- Keeps the carry in a flip-flop between bits and shifts the sum bits into a result register.
- Sits directly upstream of the combinational full-adder cell, sequencing operands into it and consuming its sum/carry outputs.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request strobe; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; sum/cout valid and updated.
- sum  output  WIDTH  registered result; holds until next done.
- cout  output  1  registered final carry; holds until next done.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous, active-low (rst_n sampled on clk rising edge).
- Reset values:
  - state=IDLE; busy=0; done=0; sum=0; cout=0.
  - Internal shift registers, carry flop and bit counter all 0.
- States:
  - IDLE: busy=0, done=0.
    - start=1 at edge E0: load a_sr<=a, b_sr<=b, carry_q<=cin, cnt<=0; go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT: busy=1, done=0. At each edge, with fa_sum/fa_carry = full add of a_sr[0], b_sr[0], carry_q:
    - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}; carry_q <= fa_carry.
    - a_sr and b_sr shift right by 1 (MSB filled with 0).
    - cnt <= cnt+1.
    - When cnt==WIDTH-1 at the edge, this is the last bit: sum <= final sum_sr value including this edge's bit, cout <= fa_carry; go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle; next edge unconditionally returns to IDLE.
- Latency:
  - start sampled at E0; shifts occur at E1..E_WIDTH; done high in the cycle after E_WIDTH.
  - Total start-to-done = WIDTH+1 cycles.
  - Throughput: one operation per WIDTH+2 cycles.
- start handling:
  - start in SHIFT or DONE is ignored, with no queueing.
  - a/b/cin changes after capture have no effect.
- Output stability: sum/cout change only on the edge entering DONE; stable in every other state.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
  - cnt width = $clog2(WIDTH+1).
  - WIDTH=1 degenerates to a single SHIFT cycle.
- Reset mid-operation: rst_n=0 at any edge forces the reset values above; the partial result is discarded and done is not asserted.
- start held high continuously: a new operation is accepted each time the block re-enters IDLE.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum (IDLE, SHIFT, DONE), 2-bit encoding.
  - CNT_W function or localparam helper.
- One sub-module: the 1-bit full-adder cell fulladdar (inputs a,b,c; outputs sum,carry), instantiated once inside serial_adder.
- Shift registers, carry flop, counter and FSM stay in the top block.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, cout=0 throughout; after release, the first start is accepted at the next edge.
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, 1-cycle start -> busy high 8 cycles, done pulse 9 cycles after start edge, sum=0x96, cout=0.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Busy ignore: start=1 again 3 cycles into a 0x10+0x20 operation with a=0xAA, b=0x55 -> result 0x30/cout=0, no second done; previous sum held stable until done.
- Reset mid-op: rst_n=0 at cycle 4 of SHIFT -> next cycle state=IDLE, busy=0, sum=0, no done; a fresh 0x01+0x01 start yields sum=0x02.
- Back-to-back: start tied high -> done every 10 cycles (WIDTH+2); start high in DONE is ignored; start=1 in IDLE is accepted.
